// File: rtl/pool_ctrl.sv
// pool_ctrl - sequencer for the 2x2 max-pooling datapath.
//
// Walks a row-major feature map held in an input buffer, one non-overlapping
// 2x2 window at a time. For each window it reads the four pixels, presents them
// to the pooling unit with a one-cycle pool_en, waits for the pooled result and
// writes it to the output buffer. A trailing odd column and/or row is skipped.
//
// Handshakes: rd_data is valid exactly one cycle after rd_en. pool_outen
// qualifies pool_out; it is sampled only in WAIT, and if it does not arrive
// within 4 WAIT cycles the run aborts with the sticky err flag set. wr_en is a
// single-cycle strobe that qualifies wr_addr and wr_data together.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      run request, sampled only in IDLE
//   img_w, img_h               map dimensions, latched on accepted start
//   base_in, base_out          buffer base addresses, latched on accepted start
//   busy, done, err            status: running, completion pulse, sticky timeout
//   rd_en, rd_addr, rd_data    input buffer read port
//   pool_en, pool_in1..4       window pixels to the pooling unit (TL, TR, BL, BR)
//   pool_out, pool_outen       pooled result from the pooling unit
//   wr_en, wr_addr, wr_data    output buffer write port
//   dbg_state                  current FSM state, for observation only
module pool_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] base_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_en,
    output logic [DATA_W-1:0] pool_in1,
    output logic [DATA_W-1:0] pool_in2,
    output logic [DATA_W-1:0] pool_in3,
    output logic [DATA_W-1:0] pool_in4,
    input  logic [DATA_W-1:0] pool_out,
    input  logic              pool_outen,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_POOL, S_WAIT, S_ADV, S_DONE
    } state_t;

    state_t              state;
    logic [DIM_W-1:0]    img_w_q, img_h_q;
    logic [ADDR_W-1:0]   base_in_q, base_out_q;
    logic [DIM_W-1:0]    r, c;
    logic [ADDR_W-1:0]   out_idx;
    logic [1:0]          wait_cnt;

    // Next window position, evaluated for the ADV step.
    // c+2 > img_w-2 is rewritten as c+4 > img_w to avoid underflow.
    logic                row_wrap, map_end;
    logic [DIM_W-1:0]    c_nx, r_nx;
    logic [2*DIM_W-1:0]  prod;
    logic [ADDR_W-1:0]   nxt_addr;

    assign row_wrap = ({1'b0, c} + (DIM_W+1)'(4)) > {1'b0, img_w_q};
    assign map_end  = row_wrap && (({1'b0, r} + (DIM_W+1)'(4)) > {1'b0, img_h_q});
    assign c_nx     = row_wrap ? '0 : c + DIM_W'(2);
    assign r_nx     = row_wrap ? r + DIM_W'(2) : r;
    // Row offset is formed at full product width, then truncated to the bus.
    assign prod     = {{DIM_W{1'b0}}, r_nx} * {{DIM_W{1'b0}}, img_w_q};
    assign nxt_addr = base_in_q + ADDR_W'(prod) + ADDR_W'(c_nx);

    // Strobes and status decode straight from the state register.
    assign rd_en     = (state == S_RD0) || (state == S_RD1) ||
                       (state == S_RD2) || (state == S_RD3);
    assign pool_en   = (state == S_POOL);
    assign wr_en     = (state == S_ADV);
    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            img_w_q    <= '0;
            img_h_q    <= '0;
            base_in_q  <= '0;
            base_out_q <= '0;
            r          <= '0;
            c          <= '0;
            out_idx    <= '0;
            wait_cnt   <= '0;
            err        <= 1'b0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pool_in1   <= '0;
            pool_in2   <= '0;
            pool_in3   <= '0;
            pool_in4   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_w_q    <= img_w;
                        img_h_q    <= img_h;
                        base_in_q  <= base_in;
                        base_out_q <= base_out;
                        r          <= '0;
                        c          <= '0;
                        out_idx    <= '0;
                        err        <= 1'b0;
                        rd_addr    <= base_in;
                        if ((img_w < DIM_W'(2)) || (img_h < DIM_W'(2)))
                            state <= S_DONE;
                        else
                            state <= S_RD0;
                    end
                end
                S_RD0: begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    state   <= S_RD1;
                end
                S_RD1: begin
                    pool_in1 <= rd_data;
                    // Step from top-right to bottom-left of the window.
                    rd_addr  <= rd_addr + ADDR_W'(img_w_q) - ADDR_W'(1);
                    state    <= S_RD2;
                end
                S_RD2: begin
                    pool_in2 <= rd_data;
                    rd_addr  <= rd_addr + ADDR_W'(1);
                    state    <= S_RD3;
                end
                S_RD3: begin
                    pool_in3 <= rd_data;
                    state    <= S_LAST;
                end
                S_LAST: begin
                    pool_in4 <= rd_data;
                    state    <= S_POOL;
                end
                S_POOL: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A result on the 4th WAIT cycle still counts.
                    if (pool_outen) begin
                        wr_data <= pool_out;
                        wr_addr <= base_out_q + out_idx;
                        state   <= S_ADV;
                    end else if (wait_cnt == 2'd3) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_ADV: begin
                    out_idx <= out_idx + ADDR_W'(1);
                    c       <= c_nx;
                    r       <= r_nx;
                    if (map_end) begin
                        state <= S_DONE;
                    end else begin
                        rd_addr <= nxt_addr;
                        state   <= S_RD0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl - self-checking bench for pool_ctrl.
//
// The model lists, per window in row-major order, the four read addresses,
// the pixel tuple and the pooled write, plus the cycle of the done pulse.
// A monitor pops those expectations whenever the DUT strobes rd_en, pool_en,
// wr_en or done. An input-buffer model and a max-pooling unit with
// programmable response delay (0 = never responds) surround the DUT.
module tb_pool_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] img_w, img_h;
    logic [AW-1:0] base_in, base_out;
    logic          busy, done, err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          pool_en;
    logic [DW-1:0] pool_in1, pool_in2, pool_in3, pool_in4;
    logic [DW-1:0] pool_out;
    logic          pool_outen;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    dbg_state;

    logic [DW-1:0] mem [0:65535];

    logic [AW-1:0]      exp_rd_q[$];
    logic [4*DW-1:0]    exp_pix_q[$];
    logic [AW+DW-1:0]   exp_wr_q[$];
    int                 exp_done_q[$];

    int cyc = 0;
    int start_cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int pool_delay = 1;
    int pcnt;

    pool_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_w      (img_w),
        .img_h      (img_h),
        .base_in    (base_in),
        .base_out   (base_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pool_en    (pool_en),
        .pool_in1   (pool_in1),
        .pool_in2   (pool_in2),
        .pool_in3   (pool_in3),
        .pool_in4   (pool_in4),
        .pool_out   (pool_out),
        .pool_outen (pool_outen),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment models ----------------
    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= 0;
            pool_outen <= 1'b0;
            pool_out   <= '0;
        end else begin
            pool_outen <= 1'b0;
            if (pool_en) begin
                if (pool_delay == 1) begin
                    pool_outen <= 1'b1;
                    pool_out   <= max4(pool_in1, pool_in2, pool_in3, pool_in4);
                end else if (pool_delay > 1) begin
                    pcnt <= pool_delay - 1;
                end
            end else if (pcnt > 0) begin
                if (pcnt == 1) begin
                    pool_outen <= 1'b1;
                    pool_out   <= max4(pool_in1, pool_in2, pool_in3, pool_in4);
                end
                pcnt <= pcnt - 1;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - start_cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event with value %0h, expected none (cycle %0d)",
                 name, act, cyc - start_cyc);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (exp_rd_q.size() == 0) unexpected("rd_en", 64'(rd_addr));
                else check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
            end
            if (pool_en) begin
                if (exp_pix_q.size() == 0) unexpected("pool_en", {pool_in1, pool_in2, pool_in3, pool_in4});
                else check("pool_in", {pool_in1, pool_in2, pool_in3, pool_in4}, exp_pix_q.pop_front());
            end
            if (wr_en) begin
                if (exp_wr_q.size() == 0) unexpected("wr_en", 64'({wr_addr, wr_data}));
                else check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(exp_wr_q.pop_front()));
            end
            if (done) begin
                if (exp_done_q.size() == 0) unexpected("done", 64'(cyc - start_cyc));
                else check("done_cycle", 64'(cyc - start_cyc), 64'(exp_done_q.pop_front()));
            end
        end
    end

    // ---------------- reference model ----------------
    // Returns the expected err flag for the run.
    function automatic bit build_expect(input int w, input int h,
                                        input logic [AW-1:0] bi, input logic [AW-1:0] bo,
                                        input int d);
        int n;
        int idx;
        logic [AW-1:0] a0, a1, a2, a3;
        n = (w / 2) * (h / 2);
        if (n == 0) begin
            exp_done_q.push_back(1);
            return 1'b0;
        end
        idx = 0;
        for (int wy = 0; wy < h / 2; wy++) begin
            for (int wx = 0; wx < w / 2; wx++) begin
                a0 = bi + AW'((2 * wy) * w) + AW'(2 * wx);
                a1 = a0 + AW'(1);
                a2 = a0 + AW'(w);
                a3 = a2 + AW'(1);
                exp_rd_q.push_back(a0);
                exp_rd_q.push_back(a1);
                exp_rd_q.push_back(a2);
                exp_rd_q.push_back(a3);
                exp_pix_q.push_back({mem[a0], mem[a1], mem[a2], mem[a3]});
                if (d == 0) begin
                    // First window times out: POOL at 6, WAIT 7..10, DONE at 11.
                    exp_done_q.push_back(11);
                    return 1'b1;
                end
                exp_wr_q.push_back({bo + AW'(idx), max4(mem[a0], mem[a1], mem[a2], mem[a3])});
                idx++;
            end
        end
        exp_done_q.push_back(n * (7 + d) + 1);
        return 1'b0;
    endfunction

    // ---------------- driver ----------------
    task automatic run(input int w, input int h, input logic [AW-1:0] bi,
                       input logic [AW-1:0] bo, input int d,
                       input bit restart, input int rst_at);
        bit exp_err;
        bit finished;
        int n;
        n = (w / 2) * (h / 2);
        finished = 1'b0;
        @(negedge clk);
        pool_delay = d;
        exp_err    = build_expect(w, h, bi, bo, d);
        img_w      = NW'(w);
        img_h      = NW'(h);
        base_in    = bi;
        base_out   = bo;
        start      = 1'b1;
        start_cyc  = cyc;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            start = restart && (k == 3);
            if (k == 1) check("busy_cycle1", 64'(busy), 64'(n > 0));
            if (rst_at == k) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_err", 64'(err), 64'd0);
                check("rst_rd_en", 64'(rd_en), 64'd0);
                check("rst_pool_en", 64'(pool_en), 64'd0);
                check("rst_wr_en", 64'(wr_en), 64'd0);
                check("rst_rd_addr", 64'(rd_addr), 64'd0);
                check("rst_wr_addr", 64'(wr_addr), 64'd0);
                check("rst_wr_data", 64'(wr_data), 64'd0);
                check("rst_pool_in", {pool_in1, pool_in2, pool_in3, pool_in4}, 64'd0);
                exp_rd_q.delete();
                exp_pix_q.delete();
                exp_wr_q.delete();
                exp_done_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
            if (done) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) unexpected("done_timeout", 64'd600);
        check("err", 64'(err), 64'(exp_err));
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("rd_left", 64'(exp_rd_q.size()), 64'd0);
        check("pix_left", 64'(exp_pix_q.size()), 64'd0);
        check("wr_left", 64'(exp_wr_q.size()), 64'd0);
        check("done_left", 64'(exp_done_q.size()), 64'd0);
        exp_rd_q.delete();
        exp_pix_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        img_w    = '0;
        img_h    = '0;
        base_in  = '0;
        base_out = '0;
        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 16; i++) mem[16'h0100 + i] = DW'(i + 1);

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_strobes", 64'({rd_en, pool_en, wr_en}), 64'd0);
        check("reset_addrs", 64'({rd_addr, wr_addr, wr_data}), 64'd0);
        check("reset_pool_in", {pool_in1, pool_in2, pool_in3, pool_in4}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4 map, values 1..16, immediate pooling response: done at 33.
        run(4, 4, 16'h0100, 16'h0200, 1, 1'b0, 0);
        // 5x3 map: two windows, last column and row untouched.
        run(5, 3, 16'h0300, 16'h0400, 1, 1'b0, 0);
        // Degenerate map: done at cycle 1, no accesses.
        run(1, 8, 16'h0500, 16'h0600, 1, 1'b0, 0);
        // Pooling unit never answers: err and early done.
        run(4, 4, 16'h0100, 16'h0200, 0, 1'b0, 0);
        // Next start clears err; slowest accepted response.
        run(4, 4, 16'h0100, 16'h0200, 4, 1'b0, 0);
        // Second start during a run is ignored.
        run(4, 4, 16'h0100, 16'h0200, 1, 1'b1, 0);
        // Reset in cycle 7, then the first scenario again.
        run(4, 4, 16'h0100, 16'h0200, 1, 1'b0, 7);
        run(4, 4, 16'h0100, 16'h0200, 1, 1'b0, 0);
        // Address wrap on both buffers.
        run(6, 4, 16'hFFFA, 16'hFFFE, 2, 1'b0, 0);

        for (int t = 0; t < 12; t++) begin
            run(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                AW'($urandom), AW'($urandom), int'($urandom_range(1, 4)), 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Sequencer for the 2x2 max-pooling datapath. It walks a row-major feature map in a read buffer, fetches the four pixels of each non-overlapping 2x2 window, and drives them into the pooling unit as one enable pulse. It then writes each pooled result into an output buffer and reports completion. It sits between the feature-map SRAMs and the pooling unit in the accelerator pipeline.

## Interface
- DATA_W, 16, pixel and pooled-result width
- ADDR_W, 16, buffer address width
- DIM_W, 8, width of the image dimension inputs

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run; sampled only in IDLE
- img_w, img_h  in  DIM_W  map width and height in pixels; latched on accepted start
- base_in, base_out  in  ADDR_W  input and output buffer base addresses; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle completion pulse
- err  out  1  sticky pooling-timeout flag; cleared on the next accepted start
- rd_en  out  1  read strobe to the input buffer
- rd_addr  out  ADDR_W  read address
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
- pool_en  out  1  enable to the pooling unit
- pool_in1..pool_in4  out  DATA_W  window pixels: top-left, top-right, bottom-left, bottom-right
- pool_out  in  DATA_W  pooled result
- pool_outen  in  1  pooled result valid
- wr_en  out  1  write strobe to the output buffer
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data

## Operation
- FSM states: IDLE, RD0, RD1, RD2, RD3, LAST, POOL, WAIT, ADV, DONE.
- All outputs are registered or decoded from the state register only. There is no combinational input-to-output path.
- IDLE, on start:
  - latch config and clear err and counters.
  - If img_w<2 or img_h<2, go to DONE with no buffer access.
  - Otherwise go to RD0.
- RD0..RD3:
  - rd_en=1 for each state.
  - rd_addr = base_in + r*img_w + c, then +1, then +img_w, then +img_w+1, where (r,c) is the window's top-left pixel.
  - rd_data arriving in RD1, RD2, RD3 and LAST is captured into pool_in1..pool_in4 respectively.
- LAST: captures pool_in4. rd_en=0.
- POOL: pool_en=1 for exactly one cycle. pool_in1..4 stay stable from LAST until the next RD1 capture.
- WAIT:
  - When pool_outen=1, register wr_data<=pool_out and wr_addr<=base_out+out_idx, then go to ADV.
  - If pool_outen has not appeared after 4 WAIT cycles, set err=1 and go to DONE. No write occurs for that window.
- ADV:
  - wr_en=1 for one cycle, then out_idx+=1 and c+=2.
  - If c+2 > img_w-2, set c=0 and r+=2.
  - If the new r > img_h-2, go to DONE; otherwise go to RD0.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Odd dimensions: the trailing column and/or row are skipped. Output count is floor(img_w/2)*floor(img_h/2).
- Address arithmetic: all address arithmetic is modulo 2^ADDR_W and wraps silently. The r*img_w product is computed at 2*DIM_W bits, then truncated.
- start while busy is ignored. A start coincident with DONE is ignored; it must be reasserted in IDLE.
- Reset values: state=IDLE; busy, done, err, rd_en, pool_en, wr_en = 0; rd_addr, wr_addr, wr_data, pool_in1..4 = 0.
- Reset mid-run: immediate return to the reset values. No partial write completes.

## Timing
- start sampled high in IDLE at cycle 0. Then:
  - RD0 in cycle 1, with busy=1 from cycle 1.
  - pool_en in cycle 6.
  - With a unit that responds next cycle (pool_outen in cycle 7), wr_en is in cycle 8.
- Steady state is 8 cycles per window. Each additional cycle of pool_outen delay adds one cycle.
- A map with N windows asserts done in cycle 8N+1 with an immediate-response pooling unit.
- A degenerate map asserts done in cycle 1.

## Test plan
- 4x4 map at base_in=0x0100 holding values 1..16 row-major, base_out=0x0200 -> rd_addr order 0x100,0x101,0x104,0x105,0x102,…. Writes are {6,8,14,16} to 0x200..0x203. done is in cycle 33.
- 5x3 map -> 2 windows and 2 writes. Column 4 and row 2 are never read.
- img_w=1, img_h=8, then start -> done in cycle 1. No rd_en and no wr_en; err=0.
- pool_outen held low -> err=1 after 4 WAIT cycles, then done, no wr_en. The next start clears err.
- start pulsed again in cycle 3 of a run -> ignored; the read sequence and output count are unchanged.
- rst_n asserted in cycle 7 of a 4x4 run -> all outputs go to reset values immediately. A fresh start then reproduces the first scenario exactly.
